imm_gen_pipe: RTL and testbench

Registered, parametrised immediate generator for the ID stage of the RV32IM pipeline. It succeeds the combinational SIGN_EXTEND. It accepts an instruction word plus an immediate-select code over a valid/ready handshake, and decodes the immediate to XLEN bits with per-format sign or zero extension. The result is delivered one cycle later through a two-entry skid buffer, so that ID/EX backpressure never creates a combinational ready path. An opaque tag (PC or rd index) travels alongside each immediate.

---
 rtl/imm_gen_pkg.sv | 24 ++
 rtl/imm_decode.sv | 66 ++++++
 rtl/imm_gen_pipe.sv | 92 +++++++++
 tb/tb_imm_gen_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared definitions for the registered immediate generator (imm_gen_pipe).
// Entry fields are sized for the widest XLEN/TAG_W (64); instances use the low bits.
package imm_gen_pkg;

  localparam logic [2:0] IMM_U     = 3'b000;
  localparam logic [2:0] IMM_J     = 3'b001;
  localparam logic [2:0] IMM_I     = 3'b010;
  localparam logic [2:0] IMM_B     = 3'b011;
  localparam logic [2:0] IMM_S     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_NONE  = 3'b111;

  localparam int unsigned U_EXT     = 3;
  localparam int unsigned IMM_W_MAX = 64;
  localparam int unsigned TAG_W_MAX = 64;

  typedef struct packed {
    logic [IMM_W_MAX-1:0] imm;
    logic [TAG_W_MAX-1:0] tag;
    logic                 illegal;
  } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decode (INST, IMM_SEL) -> (imm, illegal).
// IMM_GEN_ZIMM_EN enables the CSR zimm format on code 110; otherwise it is illegal.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [3:0]      imm_sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] raw;
  logic        sext;
  logic        zext;
  logic        unused_opcode;

  assign zext          = imm_sel[U_EXT];
  assign unused_opcode = ^inst[6:0];

  // raw is the immediate at 32 bits; sext decides how it widens to XLEN
  always_comb begin
    raw     = '0;
    sext    = 1'b0;
    illegal = 1'b0;
    case (imm_sel[2:0])
      IMM_U: begin
        raw  = {inst[31:12], 12'b0};
        sext = !zext;
      end
      IMM_J: begin
        raw  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        sext = 1'b1;
      end
      IMM_I: begin
        raw  = zext ? {20'b0, inst[31:20]} : {{20{inst[31]}}, inst[31:20]};
        sext = !zext;
      end
      IMM_B: begin
        raw  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        sext = 1'b1;
      end
      IMM_S: begin
        raw  = zext ? {20'b0, inst[31:25], inst[11:7]}
                    : {{20{inst[31]}}, inst[31:25], inst[11:7]};
        sext = !zext;
      end
      IMM_SHAMT: begin
        raw = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
      end
      IMM_ZIMM: begin
`ifdef IMM_GEN_ZIMM_EN
        raw = {27'b0, inst[19:15]};
`else
        illegal = 1'b1;
`endif
      end
      IMM_NONE: begin
        raw = '0;
      end
    endcase
    imm = sext ? XLEN'(signed'(raw)) : XLEN'(raw);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode at acceptance, deliver through a 2-entry
// skid buffer (M main, K skid). IMM_GEN_ZIMM_EN selects the zimm build. TAG_W <= 64.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [31:0]      INST,
  input  logic [3:0]       IMM_SEL,
  input  logic [TAG_W-1:0] IN_TAG,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [XLEN-1:0]  OUT_IMM,
  output logic [TAG_W-1:0] OUT_TAG,
  output logic             OUT_ILLEGAL
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  imm_entry_t      in_entry;
  imm_entry_t      m_q;
  imm_entry_t      k_q;
  logic            m_valid;
  logic            k_valid;
  logic            in_ready_q;
  logic            accept;
  logic            m_free;
  logic            unused_entry_bits;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (INST),
    .imm_sel (IMM_SEL),
    .imm     (dec_imm),
    .illegal (dec_illegal)
  );

  always_comb begin
    in_entry         = '0;
    in_entry.imm     = IMM_W_MAX'(dec_imm);
    in_entry.tag     = TAG_W_MAX'(IN_TAG);
    in_entry.illegal = dec_illegal;
  end

  assign accept = IN_VALID && in_ready_q;
  assign m_free = !m_valid || OUT_READY;

  // K is only ever occupied while M holds an entry, and IN_READY tracks !K.valid,
  // so an accept never coincides with a K->M move.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_q        <= '0;
      k_q        <= '0;
      m_valid    <= 1'b0;
      k_valid    <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (FLUSH) begin
      m_valid    <= 1'b0;
      k_valid    <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (m_free) begin
      if (k_valid) begin
        m_q        <= k_q;
        m_valid    <= 1'b1;
        k_valid    <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (accept) begin
        m_q     <= in_entry;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      k_q        <= in_entry;
      k_valid    <= 1'b1;
      in_ready_q <= 1'b0;
    end
  end

  assign IN_READY          = in_ready_q;
  assign OUT_VALID         = m_valid;
  assign OUT_IMM           = m_q.imm[XLEN-1:0];
  assign OUT_TAG           = m_q.tag[TAG_W-1:0];
  assign OUT_ILLEGAL       = m_q.illegal;
  assign unused_entry_bits = ^{m_q.imm, m_q.tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus
// and are checked against a FIFO-of-decoded-immediates model plus literal vectors.
module tb_imm_gen_pipe;

  logic        CLK       = 1'b0;
  logic        RESET_N   = 1'b1;
  logic        FLUSH     = 1'b0;
  logic        IN_VALID  = 1'b0;
  logic        OUT_READY = 1'b0;
  logic [31:0] INST      = '0;
  logic [3:0]  IMM_SEL   = '0;
  logic [31:0] IN_TAG    = '0;

  logic        rdy32, rdy64, v32, v64, ill32, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(rdy32),
    .INST(INST), .IMM_SEL(IMM_SEL), .IN_TAG(IN_TAG), .OUT_VALID(v32), .OUT_READY(OUT_READY),
    .OUT_IMM(imm32), .OUT_TAG(tag32), .OUT_ILLEGAL(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .CLK(CLK), .RESET_N(RESET_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(rdy64),
    .INST(INST), .IMM_SEL(IMM_SEL), .IN_TAG(IN_TAG), .OUT_VALID(v64), .OUT_READY(OUT_READY),
    .OUT_IMM(imm64), .OUT_TAG(tag64), .OUT_ILLEGAL(ill64)
  );

  typedef struct {
    logic [63:0] e32;
    logic [63:0] e64;
    logic [31:0] tag;
    logic        ill;
  } exp_t;

  exp_t q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Field value extracted arithmetically, then two's-complement adjusted if signed.
  function automatic logic [63:0] model_imm(input logic [31:0] i, input logic [3:0] sel,
                                            input int xlen);
    longint v   = 0;
    int     w   = 32;
    bit     sgn = 1'b0;
    case (sel[2:0])
      3'd0: begin v = longint'(i[31:12]) * 4096; w = 32; sgn = !sel[3]; end
      3'd1: begin
        v = longint'(i[31]) * (2**20) + longint'(i[19:12]) * (2**12)
          + longint'(i[20]) * (2**11) + longint'(i[30:21]) * 2;
        w = 21; sgn = 1'b1;
      end
      3'd2: begin v = longint'(i[31:20]); w = 12; sgn = !sel[3]; end
      3'd3: begin
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048
          + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        w = 13; sgn = 1'b1;
      end
      3'd4: begin v = longint'(i[31:25]) * 32 + longint'(i[11:7]); w = 12; sgn = !sel[3]; end
      3'd5: v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
`ifdef IMM_GEN_ZIMM_EN
      3'd6: v = longint'(i[19:15]);
`else
      3'd6: v = 0;
`endif
      default: v = 0;
    endcase
    if (sgn && v >= (longint'(1) << (w - 1))) v = v - (longint'(1) << w);
    if (xlen == 32) return {32'h0, v[31:0]};
    return v;
  endfunction

  function automatic logic model_ill(input logic [3:0] sel);
`ifdef IMM_GEN_ZIMM_EN
    return 1'b0;
`else
    return sel[2:0] == 3'd6;
`endif
  endfunction

  // Compare DUT outputs with the model, then advance the model over the coming edge.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1) begin
      bit   acc;
      exp_t e;
      check("valid32", 64'(v32), 64'(q.size() > 0));
      check("valid64", 64'(v64), 64'(q.size() > 0));
      check("ready32", 64'(rdy32), 64'(q.size() < 2));
      check("ready64", 64'(rdy64), 64'(q.size() < 2));
      if (q.size() > 0) begin
        check("imm32", 64'(imm32), q[0].e32);
        check("imm64", imm64, q[0].e64);
        check("tag32", 64'(tag32), 64'(q[0].tag));
        check("tag64", 64'(tag64), 64'(q[0].tag));
        check("ill32", 64'(ill32), 64'(q[0].ill));
        check("ill64", 64'(ill64), 64'(q[0].ill));
      end
      if (FLUSH) begin
        q.delete();
      end else begin
        acc   = IN_VALID && (q.size() < 2);
        e.e32 = model_imm(INST, IMM_SEL, 32);
        e.e64 = model_imm(INST, IMM_SEL, 64);
        e.tag = IN_TAG;
        e.ill = model_ill(IMM_SEL);
        if (OUT_READY && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic lit(input string nm, input logic [31:0] inst, input logic [3:0] sel,
                     input logic [63:0] x32, input logic [63:0] x64, input logic xill);
    IN_VALID = 1'b1;
    INST     = inst;
    IMM_SEL  = sel;
    IN_TAG   = IN_TAG + 32'd1;
    step();
    IN_VALID = 1'b0;
    check({nm, "_valid"}, 64'(v32), 64'd1);
    check({nm, "_x32"}, 64'(imm32), x32);
    check({nm, "_x64"}, imm64, x64);
    check({nm, "_ill"}, 64'(ill64), 64'(xill));
  endtask

  task automatic reset_vals(input string nm);
    check({nm, "_v"}, {62'd0, v32, v64}, 64'd0);
    check({nm, "_imm32"}, 64'(imm32), 64'd0);
    check({nm, "_imm64"}, imm64, 64'd0);
    check({nm, "_tag"}, {tag32, tag64}, 64'd0);
    check({nm, "_ill"}, {62'd0, ill32, ill64}, 64'd0);
    check({nm, "_rdy"}, {62'd0, rdy32, rdy64}, 64'd3);
  endtask

  logic [31:0] insts [5] = '{32'hFFF00013, 32'h80000037, 32'hFE000EE3, 32'h03F09093, 32'h12345678};
  logic [15:0] rpat = 16'b1011_0010_1110_0101;

  initial begin
    int cyc;
    int budget;
    bit rdy;

    #1 RESET_N = 1'b0;
    #1 reset_vals("por");
    step();
    step();
    RESET_N   = 1'b1;
    OUT_READY = 1'b1;

    lit("i_sext", 32'hFFF00013, 4'b0010, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    lit("i_zext", 32'hFFF00013, 4'b1010, 64'h00000FFF, 64'h00000000_00000FFF, 1'b0);
    lit("u_sext", 32'h80000037, 4'b0000, 64'h80000000, 64'hFFFFFFFF_80000000, 1'b0);
    lit("u_zext", 32'h80000037, 4'b1000, 64'h80000000, 64'h00000000_80000000, 1'b0);
    lit("b_beq",  32'hFE000EE3, 4'b0011, 64'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
    lit("b_uext", 32'hFE000EE3, 4'b1011, 64'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
    lit("s_sw",   32'hFE002FA3, 4'b0100, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    lit("shamt",  32'h03F09093, 4'b0101, 64'h0000001F, 64'h00000000_0000003F, 1'b0);
    lit("j_jal",  32'hFFDFF06F, 4'b0001, 64'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0);
    lit("none",   32'h12345678, 4'b0111, 64'h0, 64'h0, 1'b0);
`ifdef IMM_GEN_ZIMM_EN
    lit("zimm",   32'h00050073, 4'b0110, 64'hA, 64'hA, 1'b0);
`else
    lit("zimm",   32'h00050073, 4'b0110, 64'h0, 64'h0, 1'b1);
`endif
    step();

    // Every code on several words, with a fixed backpressure pattern.
    cyc = 0;
    for (int i = 0; i < 5; i++) begin
      for (int s = 0; s < 16; s++) begin
        IN_VALID = 1'b1;
        INST     = insts[i];
        IMM_SEL  = 4'(s);
        IN_TAG   = IN_TAG + 32'd1;
        budget   = 0;
        do begin
          rdy       = rdy32;
          OUT_READY = rpat[cyc[3:0]];
          cyc++;
          step();
          budget++;
        end while (!rdy && budget < 20);
        check("accept_in_budget", 64'(rdy), 64'd1);
      end
    end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    repeat (3) step();

    // Backpressure: tags 1,2,3 offered while the consumer stalls.
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    INST      = 32'hFFF00013;
    IMM_SEL   = 4'b0010;
    IN_TAG    = 32'd1;
    step();
    IN_TAG = 32'd2;
    step();
    check("bp_ready_low", 64'(rdy32), 64'd0);
    check("bp_head1", 64'(tag32), 64'd1);
    IN_TAG = 32'd3;
    step();
    check("bp_still_low", 64'(rdy64), 64'd0);
    check("bp_hold1", 64'(tag64), 64'd1);
    OUT_READY = 1'b1;
    step();
    check("bp_tag2", 64'(tag32), 64'd2);
    check("bp_ready_back", 64'(rdy32), 64'd1);
    step();
    check("bp_tag3", 64'(tag32), 64'd3);
    IN_VALID = 1'b0;
    step();
    check("bp_empty", 64'(v32), 64'd0);

    // Flush with M and K full, input offered on the flush edge.
    OUT_READY = 1'b0;
    IN_VALID  = 1'b1;
    IN_TAG    = 32'h40;
    step();
    IN_TAG = 32'h41;
    step();
    FLUSH  = 1'b1;
    IN_TAG = 32'h42;
    step();
    FLUSH = 1'b0;
    check("flush_full_v", 64'(v32), 64'd0);
    check("flush_full_rdy", 64'(rdy32), 64'd1);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    step();
    check("flush_full_gone", 64'(v64), 64'd0);

    // Flush with only M full: the input is accepted on the flush edge and discarded.
    IN_VALID = 1'b1;
    IN_TAG   = 32'h50;
    step();
    OUT_READY = 1'b0;
    FLUSH     = 1'b1;
    IN_TAG    = 32'h51;
    step();
    FLUSH = 1'b0;
    check("flush_m_v", 64'(v64), 64'd0);
    check("flush_m_rdy", 64'(rdy64), 64'd1);
    IN_VALID = 1'b0;
    step();
    check("flush_m_gone", 64'(v32), 64'd0);

    // Asynchronous reset between edges with both registers full.
    IN_VALID = 1'b1;
    IN_TAG   = 32'h60;
    step();
    IN_TAG = 32'h61;
    step();
    IN_VALID = 1'b0;
    check("rst_pre_v", 64'(v32), 64'd1);
    check("rst_pre_kfull", 64'(rdy32), 64'd0);
    #2 RESET_N = 1'b0;
    #1 reset_vals("async_rst");
    q.delete();
    step();
    RESET_N   = 1'b1;
    OUT_READY = 1'b1;
    lit("post_rst", 32'hFFF00013, 4'b0010, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
